// File: rtl/i2s_rx.sv
`timescale 1ns/1ps
// i2s_rx: synchronous I2S (Philips format) slave receiver.
// Oversamples sclk/lr_clk/sdat in the CLK domain, deserialises MSB-first
// stereo words and presents left/right pairs with a one-cycle out_tick.
// Optional feature macro: I2S_RX_MONO_MIX_EN (enables the mono_out mixer;
// when undefined mono_out is tied to zero).
module i2s_rx #(
  parameter int DATA_BITS      = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 sclk,
  input  logic                 lr_clk,
  input  logic                 sdat,
  output logic [DATA_BITS-1:0] left_out,
  output logic [DATA_BITS-1:0] right_out,
  output logic [DATA_BITS-1:0] mono_out,
  output logic                 out_tick,
  output logic                 frame_err,
  output logic                 locked
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {
    ST_SYNC = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Synchroniser and edge-detect flops
  logic r_sclk_meta, r_sclk_sync, r_sclk_dly;
  logic r_lr_meta, r_lr_sync;
  logic r_sdat_meta, r_sdat_sync;

  // Control state
  state_t r_state, w_state_next;
  logic [TO_W-1:0] r_to_cnt;

  // Deserialiser state
  logic                 r_lr_prev;
  logic [CNT_W-1:0]     r_cnt;
  logic [DATA_BITS-1:0] r_sreg;
  logic [DATA_BITS-1:0] r_left_stage;
  logic                 r_left_valid;

  // Registered outputs
  logic [DATA_BITS-1:0] r_left_out;
  logic [DATA_BITS-1:0] r_right_out;
  logic                 r_out_tick;
  logic                 r_frame_err;

  // Decoded events
  logic                 w_sclk_rise;
  logic                 w_lr_change;
  logic                 w_timeout;
  logic                 w_boundary;
  logic                 w_pair_done;
  logic [DATA_BITS-1:0] w_sreg_upd;

  assign w_sclk_rise = r_sclk_sync & ~r_sclk_dly;
  assign w_lr_change = (r_lr_sync != r_lr_prev);
  // A sclk_rise in the same cycle as the timeout keeps the link alive.
  assign w_timeout   = (r_to_cnt == TO_W'(TIMEOUT_CYCLES)) && !w_sclk_rise;
  assign w_boundary  = w_sclk_rise && (r_state == ST_RUN) && w_lr_change;
  assign w_pair_done = w_boundary && r_lr_prev && r_left_valid;

  // Two-flop synchronisers on all pins, plus a third sclk flop for edge detect
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values; blocking here would collapse the sync chain.
    if (RST) begin
      r_sclk_meta <= 1'b0;
      r_sclk_sync <= 1'b0;
      r_sclk_dly  <= 1'b0;
      r_lr_meta   <= 1'b0;
      r_lr_sync   <= 1'b0;
      r_sdat_meta <= 1'b0;
      r_sdat_sync <= 1'b0;
    end else begin
      r_sclk_meta <= sclk;
      r_sclk_sync <= r_sclk_meta;
      r_sclk_dly  <= r_sclk_sync;
      r_lr_meta   <= lr_clk;
      r_lr_sync   <= r_lr_meta;
      r_sdat_meta <= sdat;
      r_sdat_sync <= r_sdat_meta;
    end
  end

  // Watchdog: counts CLK cycles since the last sclk rising edge, saturating
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_to_cnt <= '0;
    end else if (w_sclk_rise) begin
      r_to_cnt <= '0;
    end else if (r_to_cnt != TO_W'(TIMEOUT_CYCLES)) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RST) r_state <= ST_SYNC;
    else     r_state <= w_state_next;
  end

  // FSM next-state: align on an lr edge, fall back to SYNC on timeout
  always_comb begin
    // NOTE: default assignment first so no path through this block infers a latch.
    w_state_next = r_state;
    case (r_state)
      ST_SYNC: if (w_sclk_rise && w_lr_change) w_state_next = ST_RUN;
      ST_RUN:  if (w_timeout)                  w_state_next = ST_SYNC;
      default: w_state_next = ST_SYNC;
    endcase
  end

  // FSM outputs: lock indication is purely a function of state
  always_comb begin
    locked = (r_state == ST_RUN);
  end

  // Shift register with the current bit merged in at its MSB-first position;
  // once cnt has saturated at DATA_BITS no position matches and bits are dropped
  always_comb begin
    w_sreg_upd = r_sreg;
    for (int i = 0; i < DATA_BITS; i++) begin
      if (r_cnt == CNT_W'(DATA_BITS - 1 - i)) w_sreg_upd[i] = r_sdat_sync;
    end
  end

  // Deserialiser, word latching and pair routing
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_lr_prev    <= 1'b0;
      r_cnt        <= '0;
      r_sreg       <= '0;
      r_left_stage <= '0;
      r_left_valid <= 1'b0;
      r_left_out   <= '0;
      r_right_out  <= '0;
      r_out_tick   <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_out_tick  <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_sclk_rise) begin
        if (r_state == ST_SYNC) begin
          // First lr edge: the bit under it belongs to an unaligned word
          if (w_lr_change) begin
            r_lr_prev    <= r_lr_sync;
            r_cnt        <= '0;
            r_sreg       <= '0;
            r_left_valid <= 1'b0;
          end
        end else if (!w_lr_change) begin
          r_sreg <= w_sreg_upd;
          if (r_cnt != CNT_W'(DATA_BITS)) r_cnt <= r_cnt + CNT_W'(1);
        end else begin
          // Channel boundary: this bit is the LSB slot of the ending word
          if (r_cnt < CNT_W'(DATA_BITS - 1)) r_frame_err <= 1'b1;
          if (!r_lr_prev) begin
            r_left_stage <= w_sreg_upd;
            r_left_valid <= 1'b1;
          end else begin
            r_right_out <= w_sreg_upd;
            if (r_left_valid) begin
              r_left_out <= r_left_stage;
              r_out_tick <= 1'b1;
            end
          end
          r_cnt     <= '0;
          r_sreg    <= '0;
          r_lr_prev <= r_lr_sync;
        end
      end else if (w_timeout) begin
        r_left_valid <= 1'b0;
      end
    end
  end

`ifdef I2S_RX_MONO_MIX_EN
  logic [DATA_BITS-1:0] r_mono;
  logic [DATA_BITS:0]   w_mix_sum;

  // Sign-extend both channels by one bit so the sum cannot overflow
  assign w_mix_sum = {r_left_stage[DATA_BITS-1], r_left_stage}
                   + {w_sreg_upd[DATA_BITS-1], w_sreg_upd};

  // Mono mix register, updated alongside out_tick
  always_ff @(posedge CLK) begin
    if (RST)              r_mono <= '0;
    else if (w_pair_done) r_mono <= w_mix_sum[DATA_BITS:1];
  end

  assign mono_out = r_mono;
`else
  assign mono_out = '0;
`endif

  assign left_out  = r_left_out;
  assign right_out = r_right_out;
  assign out_tick  = r_out_tick;
  assign frame_err = r_frame_err;

endmodule
